// File: rtl/execute_target_unit.sv
// execute_target_unit
// Execute-stage control-transfer target generation. One of NUM_SRC base
// operands is selected and the sign-extended immediate is added to it. In JALR
// mode bit 0 of the sum is cleared. The result is then checked against the
// required instruction alignment.
// The target, valid and redirect/misalign flags sit in a single pipeline
// register with flush/stall control. A saturating counter tallies issued
// redirects for performance monitoring.
//
// Handshake: there is no backpressure towards execute. valid_i qualifies the
// instruction in the current cycle. valid_o qualifies target_o one cycle later.
// redirect_o is a single-cycle pulse to fetch and is never re-issued while the
// register is stalled.
module execute_target_unit #(
    parameter int WIDTH       = 32,
    parameter int NUM_SRC     = 2,
    parameter int ALIGN_BYTES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [NUM_SRC*WIDTH-1:0]                        src_i,
    input  logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] sel_i,
    input  logic [WIDTH-1:0]                                imm_i,
    input  logic                                            clr_lsb_i,
    input  logic                                            taken_i,
    input  logic                                            valid_i,
    input  logic                                            stall_i,
    input  logic                                            flush_i,
    output logic [WIDTH-1:0]                                target_o,
    output logic                                            valid_o,
    output logic                                            redirect_o,
    output logic                                            misalign_o,
    output logic [CNT_W-1:0]                                redirect_cnt_o
);

    // Number of low target bits that must be zero for an aligned target.
    localparam int ALIGN_LSB = (ALIGN_BYTES > 1) ? $clog2(ALIGN_BYTES) : 0;

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] tgt;
    logic             mis;
    logic             take;
    logic             capture;
    logic             redirect_d;
    logic             misalign_d;
    logic             cnt_sat;

    // Base operand mux. Select values beyond NUM_SRC-1 fall back to source 0 (PC).
    always_comb begin
        base = src_i[WIDTH-1:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (int'(sel_i) == k) begin
                base = src_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Target adder. The carry-out is dropped, so the address wraps modulo 2^WIDTH.
    // JALR mode forces bit 0 of the sum low.
    always_comb begin
        sum = base + imm_i;
        tgt = sum;
        if (clr_lsb_i) begin
            tgt[0] = 1'b0;
        end
    end

    // Alignment check. It is absent when any byte address is legal.
    generate
        if (ALIGN_LSB == 0) begin : g_no_align
            assign mis = 1'b0;
        end else begin : g_align
            assign mis = |tgt[ALIGN_LSB-1:0];
        end
    endgenerate

    // Redirect and misalign are mutually exclusive by construction.
    assign take       = valid_i & taken_i;
    assign redirect_d = take & ~mis;
    assign misalign_d = take & mis;
    assign capture    = ~flush_i & ~stall_i;
    assign cnt_sat    = &redirect_cnt_o;

    // Output register. Flush has priority over stall, and stall has priority over capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_o   <= '0;
            valid_o    <= 1'b0;
            redirect_o <= 1'b0;
            misalign_o <= 1'b0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
            redirect_o <= 1'b0;
            misalign_o <= 1'b0;
        end else if (stall_i) begin
            redirect_o <= 1'b0;
        end else begin
            target_o   <= tgt;
            valid_o    <= valid_i;
            redirect_o <= redirect_d;
            misalign_o <= misalign_d;
        end
    end

    // Redirect counter. It advances on the same edge that raises redirect_o and sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_cnt_o <= '0;
        end else if (capture && redirect_d && !cnt_sat) begin
            redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
        end
    end

    // Fetch must never see a redirect and a misalign exception together.
    a_redirect_misalign_excl : assert property (
        @(posedge clk) disable iff (!reset) !(redirect_o && misalign_o)
    );

endmodule

// File: tb/tb_execute_target_unit.sv
// Bench for execute_target_unit. It drives two configurations side by side:
//   u_a: NUM_SRC=2, ALIGN_BYTES=4, CNT_W=16
//   u_b: NUM_SRC=3, ALIGN_BYTES=2, CNT_W=4
// Both share the control inputs. A behavioural reference model predicts every
// registered output. A queue of expected redirect targets cross-checks the
// fetch pulses of u_a.
module tb_execute_target_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- stimulus ----------------
    logic [31:0] src [3];
    logic [1:0]  sel;
    logic [31:0] imm;
    logic        clr_lsb, taken, valid, stall, flush;

    logic [63:0] src_a;
    logic [95:0] src_b;
    logic [0:0]  sel_a;
    assign src_a = {src[1], src[0]};
    assign src_b = {src[2], src[1], src[0]};
    assign sel_a = sel[0];

    logic [31:0] tgt_a, tgt_b;
    logic        val_a, val_b, red_a, red_b, mis_a, mis_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    execute_target_unit #(.WIDTH(32), .NUM_SRC(2), .ALIGN_BYTES(4), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .src_i(src_a), .sel_i(sel_a), .imm_i(imm),
        .clr_lsb_i(clr_lsb), .taken_i(taken), .valid_i(valid), .stall_i(stall),
        .flush_i(flush), .target_o(tgt_a), .valid_o(val_a), .redirect_o(red_a),
        .misalign_o(mis_a), .redirect_cnt_o(cnt_a)
    );

    execute_target_unit #(.WIDTH(32), .NUM_SRC(3), .ALIGN_BYTES(2), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .src_i(src_b), .sel_i(sel), .imm_i(imm),
        .clr_lsb_i(clr_lsb), .taken_i(taken), .valid_i(valid), .stall_i(stall),
        .flush_i(flush), .target_o(tgt_b), .valid_o(val_b), .redirect_o(red_b),
        .misalign_o(mis_b), .redirect_cnt_o(cnt_b)
    );

    // ---------------- scoreboard / reference model ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];

    int nsrc  [2] = '{2, 3};
    int align [2] = '{4, 2};
    int cmax  [2] = '{65535, 15};

    logic [31:0] m_tgt [2];
    logic        m_val [2];
    logic        m_red [2];
    logic        m_mis [2];
    int          m_cnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_tgt[d] = '0; m_val[d] = 1'b0; m_red[d] = 1'b0; m_mis[d] = 1'b0; m_cnt[d] = 0;
        end
        exp_q.delete();
    endtask

    // One clock edge of the architectural behaviour for configuration d.
    task automatic model_step(input int d);
        int          s;
        logic [31:0] base, t;
        bit          bad;
        s    = (d == 0) ? int'(sel[0]) : int'(sel);
        base = (s < nsrc[d]) ? src[s] : src[0];
        t    = base + imm;
        if (clr_lsb) t = t & 32'hFFFF_FFFE;
        bad  = (t % 32'(align[d])) != 0;
        if (!reset) begin
            m_tgt[d] = '0; m_val[d] = 1'b0; m_red[d] = 1'b0; m_mis[d] = 1'b0; m_cnt[d] = 0;
        end else if (flush) begin
            m_val[d] = 1'b0; m_red[d] = 1'b0; m_mis[d] = 1'b0;
        end else if (stall) begin
            m_red[d] = 1'b0;
        end else begin
            m_tgt[d] = t;
            m_val[d] = valid;
            m_red[d] = valid && taken && !bad;
            m_mis[d] = valid && taken && bad;
            if (m_red[d] && m_cnt[d] < cmax[d]) m_cnt[d]++;
            if (d == 0 && m_red[d]) exp_q.push_back(t);
        end
    endtask

    task automatic compare_all();
        check("a_target",   tgt_a, m_tgt[0]);
        check("a_valid",    32'(val_a), 32'(m_val[0]));
        check("a_redirect", 32'(red_a), 32'(m_red[0]));
        check("a_misalign", 32'(mis_a), 32'(m_mis[0]));
        check("a_count",    32'(cnt_a), 32'(m_cnt[0]));
        check("b_target",   tgt_b, m_tgt[1]);
        check("b_valid",    32'(val_b), 32'(m_val[1]));
        check("b_redirect", 32'(red_b), 32'(m_red[1]));
        check("b_misalign", 32'(mis_b), 32'(m_mis[1]));
        check("b_count",    32'(cnt_b), 32'(m_cnt[1]));
        if (red_a) begin
            if (exp_q.size() == 0) check("a_redirect_unexpected", 32'(red_a), 32'd0);
            else check("a_redirect_queue_target", tgt_a, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [1:0] sl, input logic [31:0] im, input logic cl,
                         input logic tk, input logic vl, input logic st, input logic fl);
        src[0] = s0; src[1] = s1; src[2] = s2; sel = sl; imm = im;
        clr_lsb = cl; taken = tk; valid = vl; stall = st; flush = fl;
    endtask

    task automatic idle();
        drive(32'h0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    int saved_cnt;

    initial begin
        model_clear();
        idle();
        reset = 1'b0;

        // Reset state, with the clock running while reset is held.
        repeat (3) step();
        check("rst_target_a", tgt_a, 32'h0);
        check("rst_valid_a", 32'(val_a), 32'h0);
        check("rst_cnt_b", 32'(cnt_b), 32'h0);
        reset = 1'b1;
        repeat (2) step();
        check("idle_redirect_a", 32'(red_a), 32'h0);
        check("idle_cnt_a", 32'(cnt_a), 32'h0);

        // PC-relative backward branch.
        drive(32'h0000_1000, 32'h0, 32'h0, 2'd0, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("pcrel_target", tgt_a, 32'h0000_0FF0);
        check("pcrel_redirect", 32'(red_a), 32'h1);
        check("pcrel_cnt", 32'(cnt_a), 32'h1);
        idle();
        step();
        check("pcrel_pulse_once", 32'(red_a), 32'h0);

        // JALR to a half-aligned target.
        drive(32'h0, 32'h0000_2003, 32'h0, 2'd1, 32'h4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("jalr_a_target", tgt_a, 32'h0000_2006);
        check("jalr_a_misalign", 32'(mis_a), 32'h1);
        check("jalr_a_redirect", 32'(red_a), 32'h0);
        check("jalr_a_cnt", 32'(cnt_a), 32'h1);
        check("jalr_b_redirect", 32'(red_b), 32'h1);
        check("jalr_b_target", tgt_b, 32'h0000_2006);

        // Stall after a taken redirect holds the target and suppresses repeats.
        drive(32'h0000_3000, 32'h0, 32'h0, 2'd0, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("stall_first_redirect", 32'(red_a), 32'h1);
        drive(32'h0000_5000, 32'h0, 32'h0, 2'd0, 32'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_target_hold", tgt_a, 32'h0000_3010);
            check("stall_no_redirect", 32'(red_a), 32'h0);
        end
        flush = 1'b1;
        step();
        check("flush_stall_valid", 32'(val_a), 32'h0);
        saved_cnt = m_cnt[0];
        stall = 1'b0;
        step();
        check("flush_taken_redirect", 32'(red_a), 32'h0);
        check("flush_taken_cnt", 32'(cnt_a), 32'(saved_cnt));

        // Address wrap-around and an out-of-range select.
        drive(32'hFFFF_FFFC, 32'h1111_1110, 32'h2222_2220, 2'd0, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check("wrap_target", tgt_a, 32'h0000_0004);
        sel = 2'd3;
        step();
        check("sel_oor_target_b", tgt_b, 32'h0000_0004);
        sel = 2'd2;
        step();
        check("sel2_target_b", tgt_b, 32'h2222_2228);

        // Counter saturation on the narrow counter.
        drive(32'h0000_0100, 32'h0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (20) step();
        check("sat_cnt_b", 32'(cnt_b), 32'd15);

        // Asynchronous reset in the middle of a stall, checked before the next edge.
        stall = 1'b1;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_cnt_a", 32'(cnt_a), 32'h0);
        check("async_rst_cnt_b", 32'(cnt_b), 32'h0);
        check("async_rst_target_a", tgt_a, 32'h0);
        check("async_rst_valid_b", 32'(val_b), 32'h0);
        model_clear();
        step();
        reset = 1'b1;
        idle();
        step();

        // Randomized traffic checked against the model every cycle.
        for (int i = 0; i < 400; i++) begin
            src[0]  = $urandom();
            src[1]  = $urandom();
            src[2]  = $urandom();
            if ($urandom_range(0, 1) == 0) src[0] = src[0] & 32'hFFFF_FFFC;
            sel     = 2'($urandom_range(0, 3));
            imm     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom();
            clr_lsb = 1'($urandom_range(0, 1));
            taken   = 1'($urandom_range(0, 1));
            valid   = ($urandom_range(0, 3) != 0);
            stall   = ($urandom_range(0, 4) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            step();
        end

        idle();
        step();
        check("redirect_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/execute_target_unit.md
Name: execute_target_unit

Overview:
- Parametrised successor to the execute-stage adder-source select.
- Selects one of NUM_SRC base operands, adds the immediate offset, optionally clears bit 0 (JALR mode) and checks target alignment.
- Registers the result in a one-stage pipeline register with stall/flush control.
- Emits a one-cycle redirect pulse to fetch and keeps a saturating count of redirects for performance monitoring.
- Sits between execute operand forwarding and the fetch PC-select logic.

Parameters:
- WIDTH, 32, datapath width of bases, offset and target.
- NUM_SRC, 2, number of selectable base operands (0 = PC, 1 = rs1 data, 2+ = extra forwarded sources); must be >= 2.
- ALIGN_BYTES, 4, required target alignment in bytes (2 = compressed ISA, 4 = base ISA); must be a power of two.
- CNT_W, 16, width of the redirect performance counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- src_i  input  NUM_SRC*WIDTH  packed base operands; source k occupies bits [k*WIDTH +: WIDTH].
- sel_i  input  max(1,$clog2(NUM_SRC))  base select.
- imm_i  input  WIDTH  sign-extended offset.
- clr_lsb_i  input  1  clear bit 0 of the sum (JALR).
- taken_i  input  1  control transfer is taken this cycle.
- valid_i  input  1  execute-stage instruction valid.
- stall_i  input  1  hold the output register.
- flush_i  input  1  kill the output register.
- target_o  output  WIDTH  registered target address.
- valid_o  output  1  registered valid.
- redirect_o  output  1  one-cycle fetch redirect pulse.
- misalign_o  output  1  registered taken-but-misaligned exception flag.
- redirect_cnt_o  output  CNT_W  saturating redirect count.

Behaviour:
- Reset (reset low, asynchronous): target_o=0, valid_o=0, redirect_o=0, misalign_o=0, redirect_cnt_o=0. Deassertion is synchronised by the consuming logic; no other side effects.
- Combinational front end:
  - base = src_i[sel_i]; sel_i >= NUM_SRC selects source 0 (PC).
  - sum = (base + imm_i) mod 2^WIDTH; carry-out is discarded and wrap-around is legal.
  - tgt = sum with bit 0 forced to 0 when clr_lsb_i=1, else sum.
  - mis = OR of tgt[log2(ALIGN_BYTES)-1:0]; mis=0 when ALIGN_BYTES=1.
- Register update, priority flush > stall > capture, evaluated each rising edge:
  - flush_i=1: valid_o=0, redirect_o=0, misalign_o=0; target_o holds; counter holds.
  - stall_i=1 (no flush): target_o, valid_o and misalign_o hold; redirect_o=0, so a redirect never repeats during a stall.
  - Otherwise capture: target_o=tgt, valid_o=valid_i, redirect_o=valid_i & taken_i & ~mis, misalign_o=valid_i & taken_i & mis.
- Latency: exactly 1 cycle from inputs to target_o/redirect_o.
- redirect_o and misalign_o are never both 1.
- Counter: increments by 1 on the same edge that sets redirect_o=1. It saturates at 2^CNT_W-1 and never wraps. Only reset clears it.
- Simultaneous flush_i and stall_i: flush wins.
- Flush in the same cycle as a taken instruction: no redirect and no count.
- Not-taken instructions still update target_o, which is don't-care for consumers when redirect_o=0.
- Reset asserted mid-stall clears all state immediately, without waiting for a clock edge.

Test Plan:
- Reset: hold reset low, toggle clk -> all outputs 0; release reset, idle inputs -> outputs remain 0.
- PC-relative branch: src0=0x0000_1000, sel=0, imm=0xFFFF_FFF0, taken=1, valid=1 -> next cycle target_o=0x0000_0FF0, redirect_o=1 for exactly one cycle, counter=1.
- JALR: src1=0x0000_2003, sel=1, imm=4, clr_lsb=1, ALIGN_BYTES=4 -> tgt=0x0000_2006, misalign_o=1, redirect_o=0, counter unchanged. Same stimulus with ALIGN_BYTES=2 -> redirect_o=1, target_o=0x0000_2006.
- Stall/flush: capture a taken redirect, then stall 3 cycles -> target_o held, redirect_o=1 only on the first cycle. Assert flush with stall -> valid_o=0 next cycle. Taken with flush=1 -> no redirect, counter unchanged.
- Wrap and out-of-range select: src0=0xFFFF_FFFC, imm=8 -> target_o=0x0000_0004. With NUM_SRC=3, sel=3 -> base is src0.
- Counter saturation: CNT_W=4, issue 20 taken redirects -> redirect_cnt_o stops at 15. Assert reset asynchronously mid-cycle -> counter reads 0 before the next edge.
